// File: rtl/div_tone_gen.sv
// Four-channel square-wave generator driven by half-period divider words.
// Each channel reloads its divider only at a half-period boundary so period changes never produce runt pulses.
module div_tone_gen #(
  parameter int WIDTH = 26
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [3:0]       EN,
  input  logic             SYNC,
  input  logic [WIDTH-1:0] Div1,
  input  logic [WIDTH-1:0] Div2,
  input  logic [WIDTH-1:0] Div3,
  input  logic [WIDTH-1:0] Div4,
  output logic [3:0]       WAVE,
  output logic [3:0]       EDGE,
  output logic [2:0]       MIX
);

  logic [WIDTH-1:0] divIn [4];
  logic [WIDTH-1:0] cnt_q [4];
  logic [WIDTH-1:0] cnt_d [4];
  logic [WIDTH-1:0] act_q [4];
  logic [WIDTH-1:0] act_d [4];
  logic [3:0]       wave_q, wave_d;
  logic [3:0]       edge_q, edge_d;
  logic [2:0]       mix_q, mix_d;

  assign divIn[0] = Div1;
  assign divIn[1] = Div2;
  assign divIn[2] = Div3;
  assign divIn[3] = Div4;

  // Per-channel priority: disable, then SYNC restart, then zero-divider stop, then counting.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i]  = cnt_q[i];
      act_d[i]  = act_q[i];
      wave_d[i] = wave_q[i];
      if (!EN[i] || SYNC) begin
        cnt_d[i]  = '0;
        wave_d[i] = 1'b0;
        act_d[i]  = divIn[i];
      end else if (divIn[i] == '0) begin
        cnt_d[i]  = '0;
        wave_d[i] = 1'b0;
        act_d[i]  = '0;
      end else if (act_q[i] == '0) begin
        cnt_d[i] = '0;
        act_d[i] = divIn[i];
      end else if (cnt_q[i] == act_q[i] - WIDTH'(1)) begin
        cnt_d[i]  = '0;
        wave_d[i] = ~wave_q[i];
        act_d[i]  = divIn[i];
      end else begin
        cnt_d[i] = cnt_q[i] + WIDTH'(1);
      end
      edge_d[i] = wave_d[i] & ~wave_q[i];
    end
    mix_d = 3'(wave_q[0]) + 3'(wave_q[1]) + 3'(wave_q[2]) + 3'(wave_q[3]);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
        act_q[i] <= '0;
      end
      wave_q <= '0;
      edge_q <= '0;
      mix_q  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
        act_q[i] <= act_d[i];
      end
      wave_q <= wave_d;
      edge_q <= edge_d;
      mix_q  <= mix_d;
    end
  end

  assign WAVE = wave_q;
  assign EDGE = edge_q;
  assign MIX  = mix_q;

endmodule
